// File: rtl/memory_exerciser.sv
// memory_exerciser: bus initiator that writes a fixed word pattern into a
// window of memory, reads it back through a registered-read responder and
// reports pass/fail, the number of mismatching words and the first bad address.
module memory_exerciser #(
    parameter int unsigned base_addr  = 0,
    parameter int unsigned addr_size  = 16,
    parameter int unsigned word_size  = 16,
    parameter int unsigned array_size = 1,
    parameter logic [array_size*word_size-1:0] array_content = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [addr_size-1:0] addr,
    output logic [word_size-1:0] data_out,
    input  logic [word_size-1:0] data_in,
    output logic                 write_en,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [addr_size-1:0] err_count,
    output logic [addr_size-1:0] first_err_addr
);

    // Index counter wide enough for 0..array_size-1 (at least one bit).
    localparam int unsigned IDX_W = (array_size > 1) ? $clog2(array_size) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(array_size - 1);
    localparam logic [addr_size-1:0] BASE     = addr_size'(base_addr);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [addr_size-1:0] addr_q, addr_d;
    logic [word_size-1:0] data_out_q, data_out_d;
    logic                 write_en_q, write_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [addr_size-1:0] err_count_q, err_count_d;
    logic [addr_size-1:0] first_err_addr_q, first_err_addr_d;
    // Set once any mismatch has been seen in the current run; independent of
    // err_count so that saturation cannot hide the first-error condition.
    logic                 err_seen_q, err_seen_d;
    // Compare pipeline: the read issued last cycle is checked this cycle.
    logic                 cmp_valid_q, cmp_valid_d;
    logic [IDX_W-1:0]     cmp_idx_q, cmp_idx_d;

    logic                 is_last;
    logic [IDX_W-1:0]     idx_inc;
    logic [word_size-1:0] expected_word;
    logic                 mismatch;

    // Pattern word for an index; a mux loop keeps N=1 free of zero-width indexing.
    function automatic logic [word_size-1:0] word_at(input logic [IDX_W-1:0] idx);
        logic [word_size-1:0] w;
        w = '0;
        for (int unsigned k = 0; k < array_size; k++) begin
            if (idx == IDX_W'(k)) begin
                w = array_content[k*word_size +: word_size];
            end
        end
        return w;
    endfunction

    assign is_last       = (idx_q == LAST_IDX);
    assign idx_inc       = idx_q + IDX_W'(1);
    assign expected_word = word_at(cmp_idx_q);
    assign mismatch      = cmp_valid_q && (data_in != expected_word);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: walk write window, read window, one drain cycle, done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_WRITE;
            S_WRITE: if (is_last) state_d = S_READ;
            S_READ:  if (is_last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (start) state_d = S_WRITE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; every output is computed one cycle ahead and registered.
    always_comb begin
        idx_d            = idx_q;
        addr_d           = addr_q;
        data_out_d       = data_out_q;
        write_en_d       = 1'b0;
        pass_d           = pass_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        err_seen_d       = err_seen_q;
        cmp_valid_d      = 1'b0;
        cmp_idx_d        = cmp_idx_q;
        busy_d           = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
        done_d           = (state_d == S_DONE);

        // Read-back check of the word whose address went out last cycle.
        if (mismatch) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + addr_size'(1);
            end
            if (!err_seen_q) begin
                err_seen_d       = 1'b1;
                first_err_addr_d = BASE + addr_size'(cmp_idx_q);
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d            = '0;
                    addr_d           = BASE;
                    data_out_d       = word_at('0);
                    write_en_d       = 1'b1;
                    pass_d           = 1'b0;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                    err_seen_d       = 1'b0;
                end
            end
            S_WRITE: begin
                if (is_last) begin
                    idx_d      = '0;
                    addr_d     = BASE;
                    data_out_d = '0;
                end else begin
                    idx_d      = idx_inc;
                    addr_d     = BASE + addr_size'(idx_inc);
                    data_out_d = word_at(idx_inc);
                    write_en_d = 1'b1;
                end
            end
            S_READ: begin
                cmp_valid_d = 1'b1;
                cmp_idx_d   = idx_q;
                data_out_d  = '0;
                if (!is_last) begin
                    idx_d  = idx_inc;
                    addr_d = BASE + addr_size'(idx_inc);
                end
            end
            S_DRAIN: begin
                pass_d = !(err_seen_q || mismatch);
            end
            default: begin
            end
        endcase
    end

    // Registered outputs and pipeline state; reset clears everything, even mid-run.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q            <= '0;
            addr_q           <= '0;
            data_out_q       <= '0;
            write_en_q       <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            err_seen_q       <= 1'b0;
            cmp_valid_q      <= 1'b0;
            cmp_idx_q        <= '0;
        end else begin
            idx_q            <= idx_d;
            addr_q           <= addr_d;
            data_out_q       <= data_out_d;
            write_en_q       <= write_en_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            err_seen_q       <= err_seen_d;
            cmp_valid_q      <= cmp_valid_d;
            cmp_idx_q        <= cmp_idx_d;
        end
    end

    assign addr           = addr_q;
    assign data_out       = data_out_q;
    assign write_en       = write_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_memory_exerciser.sv
// Testbench for memory_exerciser: two instances (normal window and a window
// that wraps past FFFF), each with a registered-read RAM model that can inject
// read faults. Expected bus traffic and results are queued when a run is
// launched and popped as the DUT produces them.
module tb_memory_exerciser;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam logic [N*DW-1:0] PAT = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic sel = 1'b0;
    int   mode = 0;

    always #5 clk = ~clk;

    logic          start_a, start_b;
    logic [AW-1:0] addr_a, addr_b, ec_a, ec_b, fe_a, fe_b;
    logic [DW-1:0] dout_a, dout_b, din_a, din_b;
    logic          we_a, we_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    memory_exerciser #(
        .base_addr(16'h0010), .addr_size(AW), .word_size(DW),
        .array_size(N), .array_content(PAT)
    ) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .addr(addr_a), .data_out(dout_a), .data_in(din_a), .write_en(we_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(ec_a), .first_err_addr(fe_a)
    );

    memory_exerciser #(
        .base_addr(16'hFFFE), .addr_size(AW), .word_size(DW),
        .array_size(N), .array_content(PAT)
    ) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .addr(addr_b), .data_out(dout_b), .data_in(din_b), .write_en(we_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(ec_b), .first_err_addr(fe_b)
    );

    // RAM models: write on strobe, registered read with optional fault injection.
    logic [DW-1:0] mem_a [0:65535];
    logic [DW-1:0] mem_b [0:65535];

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a, input logic [DW-1:0] v);
        if (mode == 2) return '0;
        if (mode == 1 && a == 16'h0012) return 16'hDEAD;
        return v;
    endfunction

    always @(posedge clk) begin
        if (we_a) mem_a[addr_a] <= dout_a;
        din_a <= model_rd(addr_a, mem_a[addr_a]);
        if (we_b) mem_b[addr_b] <= dout_b;
        din_b <= model_rd(addr_b, mem_b[addr_b]);
    end

    // View of the instance currently under test.
    logic [AW-1:0] o_addr, o_ec, o_fe;
    logic [DW-1:0] o_dout;
    logic          o_we, o_busy, o_done, o_pass;
    assign o_addr = sel ? addr_b : addr_a;
    assign o_dout = sel ? dout_b : dout_a;
    assign o_we   = sel ? we_b   : we_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_pass = sel ? pass_b : pass_a;
    assign o_ec   = sel ? ec_b   : ec_a;
    assign o_fe   = sel ? fe_b   : fe_a;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_addr"},      o_addr, 0);
        check({tag, "_data_out"},  o_dout, 0);
        check({tag, "_write_en"},  o_we,   0);
        check({tag, "_busy"},      o_busy, 0);
        check({tag, "_done"},      o_done, 0);
        check({tag, "_pass"},      o_pass, 0);
        check({tag, "_err_count"}, o_ec,   0);
        check({tag, "_first_err"}, o_fe,   0);
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        logic          p;
        logic [AW-1:0] ec;
        logic [AW-1:0] fe;
    } res_t;

    wr_t           wq[$];
    logic [AW-1:0] rq[$];
    res_t          resq[$];
    logic [DW-1:0] pat_w [N] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    // One complete run on the selected instance; start asserted for the E0 edge only
    // (plus optional stray pulses during WRITE and READ).
    task automatic run(input int md, input bit pulse,
                       input logic p, input logic [AW-1:0] ec, input logic [AW-1:0] fe);
        logic [AW-1:0] base;
        logic [AW-1:0] ra;
        wr_t  w;
        res_t r;
        int   k, nw, nr;
        bit   got;
        base = sel ? 16'hFFFE : 16'h0010;
        mode = md;
        for (int i = 0; i < N; i++) begin
            w.a = base + 16'(i);
            w.d = pat_w[i];
            wq.push_back(w);
            rq.push_back(base + 16'(i));
        end
        r.p = p; r.ec = ec; r.fe = fe;
        resq.push_back(r);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; nw = 0; nr = 0; got = 1'b0;
        check("clr_err_count", o_ec, 0);
        check("clr_first_err", o_fe, 0);
        check("clr_pass", o_pass, 0);
        while (!got && k < 40) begin
            if (o_done) begin
                got = 1'b1;
            end else begin
                check("busy_in_run", o_busy, 1);
                if (o_we) begin
                    nw++;
                    if (wq.size() > 0) begin
                        w = wq.pop_front();
                        $display("txn write addr=%h data=%h cycle=%0d", o_addr, o_dout, k);
                        check("wr_addr", o_addr, w.a);
                        check("wr_data", o_dout, w.d);
                    end
                end else if (o_busy && rq.size() > 0) begin
                    nr++;
                    ra = rq.pop_front();
                    $display("txn read  addr=%h cycle=%0d", o_addr, k);
                    check("rd_addr", o_addr, ra);
                    check("rd_data_out", o_dout, 0);
                end
                start = pulse && (k == 2 || k == 6);
                @(posedge clk); #1;
                k++;
            end
        end
        start = 1'b0;
        check("done_cycle", k, 2*N+1);
        check("writes_seen", nw, N);
        check("reads_seen", nr, N);
        check("busy_with_done", o_busy, 0);
        r = resq.pop_front();
        check("pass", o_pass, r.p);
        check("err_count", o_ec, r.ec);
        check("first_err_addr", o_fe, r.fe);
        $display("txn result sel=%0d mode=%0d done_cycle=%0d pass=%0d err_count=%0d first_err=%h",
                 sel, md, k, o_pass, o_ec, o_fe);
        wq.delete();
        rq.delete();
    endtask

    initial begin
        int seen_done;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0; check_idle("rst_a");
        sel = 1'b1; check_idle("rst_b");
        reset = 1'b1;
        sel = 1'b0;
        @(posedge clk); #1;

        // Ideal model, then single-address fault, then all-zero reads.
        run(0, 1'b0, 1'b1, 16'd0, 16'h0000);
        run(1, 1'b0, 1'b0, 16'd1, 16'h0012);
        run(2, 1'b0, 1'b0, 16'd4, 16'h0010);
        // Stray start pulses during WRITE and READ are ignored.
        run(0, 1'b1, 1'b1, 16'd0, 16'h0000);

        // Wrapping window FFFE..0001.
        sel = 1'b1;
        run(0, 1'b0, 1'b1, 16'd0, 16'h0000);
        sel = 1'b0;

        // Reset in the second WRITE cycle aborts the run.
        mode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("mid_write_we", o_we, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_idle("abort");
        $display("txn reset mid-write");
        seen_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (o_done || o_busy) seen_done++;
        end
        check("abort_no_done", seen_done, 0);

        run(0, 1'b0, 1'b1, 16'd0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
